alu_arbiter: RTL

Two-requester arbiter that shares the single 32-bit combinational ALU between a primary and a secondary client, for example the main datapath and a debug or address-generation unit. Each client hands over an ALU operation (3-bit ALU control code plus two operands) through a valid/ready handshake. The arbiter grants clients round-robin, drives the ALU from registered operands, captures the result and zero flag, and returns them on a per-client response handshake. It sits between the clients and the ALU, downstream of the ALU decoder that produces each client's control code.

---
 rtl/alu_arb_pkg.sv | 19 +
 rtl/rr_arbiter2.sv | 18 +
 rtl/alu_arbiter.sv | 113 +++++++++++
 3 files changed

// File: rtl/alu_arb_pkg.sv
// alu_arbiter shared types: FSM state encoding and ALU control codes.
// Imported by the arbiter top and its round-robin helper.
`timescale 1ns/1ps
package alu_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [2:0] ALUCTL_ADD = 3'b000;
  localparam logic [2:0] ALUCTL_SUB = 3'b001;
  localparam logic [2:0] ALUCTL_AND = 3'b010;
  localparam logic [2:0] ALUCTL_OR  = 3'b011;
  localparam logic [2:0] ALUCTL_SLT = 3'b100;
  localparam logic [2:0] ALUCTL_NOR = 3'b101;

endpackage

// File: rtl/rr_arbiter2.sv
// Combinational 2-way round-robin pick.
// Ports: valid[1:0], last in; gnt_any, gnt_id out.
`timescale 1ns/1ps
module rr_arbiter2 (
  input  logic [1:0] valid,
  input  logic       last,
  output logic       gnt_any,
  output logic       gnt_id
);

  always_comb begin
    gnt_any = |valid;
    gnt_id  = valid[1];
    // On a tie the client not served last wins.
    if (&valid) gnt_id = ~last;
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between two clients, round-robin.
// Ports: req0/req1 valid-ready ops in, rsp0/rsp1 valid-ready results out, alu_* to/from the ALU.
`timescale 1ns/1ps
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [2:0]   req0_alucontrol,
  input  logic [N-1:0] req0_a,
  input  logic [N-1:0] req0_b,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [2:0]   req1_alucontrol,
  input  logic [N-1:0] req1_a,
  input  logic [N-1:0] req1_b,
  output logic         rsp0_valid,
  input  logic         rsp0_ready,
  output logic [N-1:0] rsp0_result,
  output logic         rsp0_zero,
  output logic         rsp1_valid,
  input  logic         rsp1_ready,
  output logic [N-1:0] rsp1_result,
  output logic         rsp1_zero,
  output logic [2:0]   alu_alucontrol,
  output logic [N-1:0] alu_a,
  output logic [N-1:0] alu_b,
  input  logic [N-1:0] alu_result,
  input  logic         alu_zero
);

  state_t       state, state_nx;
  logic         last, gnt;
  logic         gnt_any, gnt_id;
  logic         accept, rsp_hs;
  logic [2:0]   op_ctl;
  logic [N-1:0] op_a, op_b;
  logic [N-1:0] res_q;
  logic         zero_q;

  rr_arbiter2 u_rr (
    .valid   ({req1_valid, req0_valid}),
    .last    (last),
    .gnt_any (gnt_any),
    .gnt_id  (gnt_id)
  );

  always_comb begin
    state_nx   = state;
    accept     = 1'b0;
    rsp_hs     = 1'b0;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    rsp0_valid = 1'b0;
    rsp1_valid = 1'b0;
    unique case (state)
      IDLE: begin
        // Reset gates ready so nothing is offered while held.
        accept     = gnt_any & ~reset;
        req0_ready = accept & ~gnt_id;
        req1_ready = accept & gnt_id;
        if (accept) state_nx = EXEC;
      end
      EXEC: state_nx = RESP;
      RESP: begin
        rsp0_valid = ~gnt;
        rsp1_valid = gnt;
        rsp_hs     = gnt ? rsp1_ready : rsp0_ready;
        if (rsp_hs) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      last   <= 1'b1;
      gnt    <= 1'b0;
      op_ctl <= '0;
      op_a   <= '0;
      op_b   <= '0;
      res_q  <= '0;
      zero_q <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        gnt    <= gnt_id;
        op_ctl <= gnt_id ? req1_alucontrol : req0_alucontrol;
        op_a   <= gnt_id ? req1_a : req0_a;
        op_b   <= gnt_id ? req1_b : req0_b;
      end
      if (state == EXEC) begin
        res_q  <= alu_result;
        zero_q <= alu_zero;
      end
      if (rsp_hs) last <= gnt;
    end
  end

  assign alu_alucontrol = op_ctl;
  assign alu_a          = op_a;
  assign alu_b          = op_b;
  assign rsp0_result    = res_q;
  assign rsp1_result    = res_q;
  assign rsp0_zero      = zero_q;
  assign rsp1_zero      = zero_q;

endmodule
